key_entry: RTL and testbench

//  Receiving end of the synckey keypad interface: consumes the 5-bit key code and strobe,

---
 rtl/key_entry_pkg.sv | 22 ++
 rtl/key_entry_if.sv | 26 ++
 rtl/key_entry_press.sv | 53 +++++
 rtl/key_entry.sv | 109 ++++++++++
 tb/tb_key_entry.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_entry_pkg.sv
// Shared key codes, FSM state type and code-to-LED decode for the keypad
// entry path.
package key_pkg;

    typedef logic [4:0] keycode_t;

    localparam keycode_t KEY_CLEAR = 5'd16;
    localparam keycode_t KEY_BACK  = 5'd17;
    localparam keycode_t KEY_ENTER = 5'd18;
    localparam keycode_t KEY_NOP   = 5'd19;
    localparam int       NUM_KEYS  = 20;

    typedef enum logic {IDLE, HELD} key_state_t;

    // Codes beyond the key map light nothing.
    function automatic logic [NUM_KEYS-1:0] key_onehot_f(input keycode_t c);
        logic [NUM_KEYS-1:0] one;
        one = 1;
        return (c < 5'(NUM_KEYS)) ? (one << c) : '0;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad-side code/strobe plus the entry results. The keypad end drives
// code/strobe; key_entry drives everything else.
interface key_entry_if
    import key_pkg::*;
#(
    parameter int DIGITS = 4
);
    keycode_t            code;
    logic                strobe;
    logic [4*DIGITS-1:0] entry;
    logic [3:0]          count;
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                overflow;
    logic [19:0]         key_onehot;

    modport master (
        output code, strobe,
        input  entry, count, value, value_valid, overflow, key_onehot
    );

    modport slave (
        input  code, strobe,
        output entry, count, value, value_valid, overflow, key_onehot
    );
endinterface

// File: rtl/key_entry_press.sv
// Turns the strobe level into a single press pulse per key-down and captures
// the code seen at that moment.
module press_detect
    import key_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  keycode_t code_i,
    input  logic     strobe_i,
    output logic     press_o,
    output keycode_t code_o,
    output logic     held_o
);
    key_state_t state_q;
    logic       press_q;
    logic       block_q;
    keycode_t   code_q;

    // block_q stops a key still held across reset from counting as a new press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            press_q <= 1'b0;
            block_q <= 1'b1;
            code_q  <= '0;
        end else begin
            press_q <= 1'b0;
            if (!strobe_i) begin
                block_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (strobe_i) begin
                        state_q <= HELD;
                        press_q <= !block_q;
                        code_q  <= code_i;
                    end
                end
                HELD: begin
                    if (!strobe_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign press_o = press_q;
    assign code_o  = code_q;
    assign held_o  = (state_q == HELD);

endmodule

// File: rtl/key_entry.sv
// Builds a multi-digit entry from keypad press events: digits shift in,
// CLEAR/BACK edit, ENTER commits with a one-cycle valid pulse.
module key_entry
    import key_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit HEX_EN = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    key_entry_if.slave  bus
);
    localparam int         W      = 4 * DIGITS;
    localparam logic [3:0] MAXCNT = 4'(DIGITS);

    logic     press;
    logic     held;
    keycode_t pcode;

    logic [W-1:0] entry_q, entry_d;
    logic [3:0]   count_q, count_d;
    logic [W-1:0] value_q, value_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic [19:0]  onehot_q, onehot_d;

    press_detect u_press (
        .clk      (clk),
        .rst      (rst),
        .code_i   (bus.code),
        .strobe_i (bus.strobe),
        .press_o  (press),
        .code_o   (pcode),
        .held_o   (held)
    );

    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        onehot_d = onehot_q;
        if (press) begin
            onehot_d = key_onehot_f(pcode);
            if (pcode < 5'd16) begin
                // With hex disabled, A-F still light their LED but edit nothing.
                if (HEX_EN || pcode < 5'd10) begin
                    if (count_q < MAXCNT) begin
                        entry_d = (entry_q << 4) | W'(pcode[3:0]);
                        count_d = count_q + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end else begin
                case (pcode)
                    KEY_CLEAR: begin
                        entry_d = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                    KEY_BACK: begin
                        if (count_q != 4'd0) begin
                            entry_d = entry_q >> 4;
                            count_d = count_q - 4'd1;
                        end
                    end
                    KEY_ENTER: begin
                        value_d = entry_q;
                        valid_d = 1'b1;
                        entry_d = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                    default: ;
                endcase
            end
        end else if (!held) begin
            onehot_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q  <= '0;
            count_q  <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            onehot_q <= '0;
        end else begin
            entry_q  <= entry_d;
            count_q  <= count_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            onehot_q <= onehot_d;
        end
    end

    assign bus.entry       = entry_q;
    assign bus.count       = count_q;
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.overflow    = ovf_q;
    assign bus.key_onehot  = onehot_q;

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry: presses push expected state, a negedge
// monitor pops on each new key LED and on each value_valid pulse.
module tb_key_entry;
    import key_pkg::*;

    typedef struct {
        logic [19:0] onehot;
        logic [15:0] entry;
        logic [3:0]  count;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int nVec = 0;
    int nErr = 0;

    exp_t        qA[$];
    exp_t        qB[$];
    logic [15:0] vqA[$];
    logic [15:0] vqB[$];
    exp_t        eA, eB;
    logic [19:0] prevOneA = '0, prevOneB = '0;
    logic        prevVvA = 1'b0, prevVvB = 1'b0;

    key_entry_if #(.DIGITS(4)) ifA ();
    key_entry_if #(.DIGITS(4)) ifB ();

    key_entry #(.DIGITS(4), .HEX_EN(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    key_entry #(.DIGITS(4), .HEX_EN(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [4:0] code, input logic strobe);
        if (sel == 0) begin
            ifA.code = code;
            ifA.strobe = strobe;
        end else begin
            ifB.code = code;
            ifB.strobe = strobe;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One key press: strobe high for 'hold' cycles, then a 2-cycle gap.
    task automatic applyStimulus(input int sel, input logic [4:0] code, input int hold,
                                 input bit expEvent, input logic [15:0] expEntry,
                                 input logic [3:0] expCount, input logic expOvf);
        exp_t        r;
        logic [19:0] one;
        one = 20'd1;
        r.onehot = one << code;
        r.entry  = expEntry;
        r.count  = expCount;
        r.ovf    = expOvf;
        if (expEvent) begin
            if (sel == 0) qA.push_back(r);
            else          qB.push_back(r);
        end
        drive(sel, code, 1'b1);
        ticks(hold);
        drive(sel, code, 1'b0);
        ticks(2);
    endtask

    task automatic expectCommit(input int sel, input logic [15:0] v);
        if (sel == 0) vqA.push_back(v);
        else          vqB.push_back(v);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, " entry A"},  32'(ifA.entry), 32'h0);
        checkOutput({tag, " count A"},  32'(ifA.count), 32'h0);
        checkOutput({tag, " value A"},  32'(ifA.value), 32'h0);
        checkOutput({tag, " valid A"},  32'(ifA.value_valid), 32'h0);
        checkOutput({tag, " ovf A"},    32'(ifA.overflow), 32'h0);
        checkOutput({tag, " onehot A"}, 32'(ifA.key_onehot), 32'h0);
        checkOutput({tag, " entry B"},  32'(ifB.entry), 32'h0);
        checkOutput({tag, " count B"},  32'(ifB.count), 32'h0);
    endtask

    always @(negedge clk) begin
        if (ifA.key_onehot != 20'd0 && prevOneA == 20'd0) begin
            if (qA.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL A event: got onehot %h expected no event", ifA.key_onehot);
            end else begin
                eA = qA.pop_front();
                checkOutput("A onehot", 32'(ifA.key_onehot), 32'(eA.onehot));
                checkOutput("A entry",  32'(ifA.entry),      32'(eA.entry));
                checkOutput("A count",  32'(ifA.count),      32'(eA.count));
                checkOutput("A ovf",    32'(ifA.overflow),   32'(eA.ovf));
            end
        end
        prevOneA = ifA.key_onehot;
        if (ifA.value_valid) begin
            checkOutput("A valid pulse width", 32'(prevVvA), 32'h0);
            if (vqA.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL A commit: got value %h expected no commit", ifA.value);
            end else begin
                checkOutput("A value", 32'(ifA.value), 32'(vqA.pop_front()));
            end
        end
        prevVvA = ifA.value_valid;

        if (ifB.key_onehot != 20'd0 && prevOneB == 20'd0) begin
            if (qB.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL B event: got onehot %h expected no event", ifB.key_onehot);
            end else begin
                eB = qB.pop_front();
                checkOutput("B onehot", 32'(ifB.key_onehot), 32'(eB.onehot));
                checkOutput("B entry",  32'(ifB.entry),      32'(eB.entry));
                checkOutput("B count",  32'(ifB.count),      32'(eB.count));
                checkOutput("B ovf",    32'(ifB.overflow),   32'(eB.ovf));
            end
        end
        prevOneB = ifB.key_onehot;
        if (ifB.value_valid) begin
            checkOutput("B valid pulse width", 32'(prevVvB), 32'h0);
            if (vqB.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL B commit: got value %h expected no commit", ifB.value);
            end else begin
                checkOutput("B value", 32'(ifB.value), 32'(vqB.pop_front()));
            end
        end
        prevVvB = ifB.value_valid;
    end

    initial begin
        // Reset with a key already held: no digit may appear on release.
        drive(0, 5'd5, 1'b1);
        drive(1, 5'd0, 1'b0);
        ticks(2);
        @(negedge clk);
        checkCleared("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        ticks(3);
        drive(0, 5'd5, 1'b0);
        ticks(2);
        checkOutput("post-reset entry A", 32'(ifA.entry), 32'h0);
        checkOutput("post-reset count A", 32'(ifA.count), 32'h0);

        applyStimulus(0, 5'd1, 3, 1, 16'h0001, 4'd1, 1'b0);
        applyStimulus(0, 5'd2, 3, 1, 16'h0012, 4'd2, 1'b0);
        applyStimulus(0, 5'd3, 3, 1, 16'h0123, 4'd3, 1'b0);
        expectCommit(0, 16'h0123);
        applyStimulus(0, KEY_ENTER, 3, 1, 16'h0000, 4'd0, 1'b0);

        // Long hold with the code changing mid-press: a single 7 only.
        qA.push_back('{onehot: 20'h00080, entry: 16'h0007, count: 4'd1, ovf: 1'b0});
        drive(0, 5'd7, 1'b1);
        ticks(5);
        drive(0, 5'd8, 1'b1);
        ticks(5);
        drive(0, 5'd8, 1'b0);
        ticks(2);
        checkOutput("hold entry A", 32'(ifA.entry), 32'h0007);
        applyStimulus(0, KEY_CLEAR, 3, 1, 16'h0000, 4'd0, 1'b0);

        applyStimulus(0, 5'd4, 3, 1, 16'h0004, 4'd1, 1'b0);
        applyStimulus(0, 5'd5, 3, 1, 16'h0045, 4'd2, 1'b0);
        applyStimulus(0, 5'd6, 3, 1, 16'h0456, 4'd3, 1'b0);
        applyStimulus(0, 5'd7, 3, 1, 16'h4567, 4'd4, 1'b0);
        applyStimulus(0, 5'd9, 3, 1, 16'h4567, 4'd4, 1'b1);
        applyStimulus(0, KEY_BACK, 3, 1, 16'h0456, 4'd3, 1'b1);
        expectCommit(0, 16'h0456);
        applyStimulus(0, KEY_ENTER, 3, 1, 16'h0000, 4'd0, 1'b0);
        expectCommit(0, 16'h0000);
        applyStimulus(0, KEY_ENTER, 2, 1, 16'h0000, 4'd0, 1'b0);
        applyStimulus(0, KEY_BACK, 1, 1, 16'h0000, 4'd0, 1'b0);
        applyStimulus(0, 5'd15, 3, 1, 16'h000F, 4'd1, 1'b0);
        applyStimulus(0, 5'd25, 3, 0, 16'h000F, 4'd1, 1'b0);
        applyStimulus(0, 5'd10, 3, 1, 16'h00FA, 4'd2, 1'b0);
        applyStimulus(0, KEY_NOP, 3, 1, 16'h00FA, 4'd2, 1'b0);

        // Reset mid-entry while a key is down; that key must not register after.
        rst = 1'b0;
        drive(0, 5'd3, 1'b1);
        ticks(2);
        @(negedge clk);
        checkCleared("mid reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        ticks(3);
        drive(0, 5'd3, 1'b0);
        ticks(2);
        applyStimulus(0, 5'd2, 3, 1, 16'h0002, 4'd1, 1'b0);

        applyStimulus(1, 5'd12, 3, 1, 16'h0000, 4'd0, 1'b0);
        applyStimulus(1, 5'd3, 3, 1, 16'h0003, 4'd1, 1'b0);

        ticks(5);
        checkOutput("A events left", 32'(qA.size()), 32'h0);
        checkOutput("B events left", 32'(qB.size()), 32'h0);
        checkOutput("A commits left", 32'(vqA.size()), 32'h0);
        checkOutput("B commits left", 32'(vqB.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
